// File: rtl/fb_scanout.sv
// fb_scanout - reads the 256-byte CHIP-8 framebuffer (64x32, 1 bpp) out of
// CPU memory with the single-byte read request/ack protocol and serializes
// it MSB-first onto a pixel stream, one frame per accepted start pulse.
//
// Optional feature macro: FB_SCANOUT_PREFETCH_EN. When defined, a second byte
// buffer fetches byte n+1 while byte n is shifting, giving a gapless stream.
// Default build: single buffer, one REQ between every byte.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               begin one frame (sampled only in IDLE)
//   busy                frame in progress
//   frame_done          one-cycle pulse after the last pixel handshake
//   mem_read            read request, held until mem_read_ack
//   mem_read_idx [11:0] byte address, stable while mem_read is high
//   mem_read_ack        response strobe, mem_read_byte valid with it
//   mem_read_byte [7:0] read data
//   pix_valid/pix_ready pixel stream handshake
//   pix_data            pixel value, 1 = lit
//   pix_x [5:0], pix_y [4:0], pix_last   pixel coordinates, last = (63,31)
//   o_dbg_state [1:0]   FSM state for checkers (0 IDLE, 1 REQ, 2 SHIFT)
//
// Handshakes: a pixel transfers on every rising edge where pix_valid and
// pix_ready are both high; pix_valid never drops and the pixel fields never
// change until that transfer. A read completes on the first rising edge,
// from the cycle after mem_read went high, where mem_read_ack is high.
module fb_scanout #(
    parameter logic [11:0] FB_BASE = 12'h100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        frame_done,
    output logic        mem_read,
    output logic [11:0] mem_read_idx,
    input  logic        mem_read_ack,
    input  logic [7:0]  mem_read_byte,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_data,
    output logic [5:0]  pix_x,
    output logic [4:0]  pix_y,
    output logic        pix_last,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_shreg;
    logic        r_pend;
    logic        r_done;

    logic        w_hs;
    logic        w_ack_ok;
    logic        w_byte_end;
    logic        w_last_byte;
    logic        w_load_shreg;
    logic [7:0]  w_load_byte;
    logic [2:0]  w_col;

`ifdef FB_SCANOUT_PREFETCH_EN
    logic        r_pf_req;
    logic        r_pf_full;
    logic [7:0]  r_pf_buf;
`endif

    assign busy        = (r_state != S_IDLE);
    assign frame_done  = r_done;
    assign o_dbg_state = r_state;
    assign w_col       = 3'd7 - r_bit;
    assign w_last_byte = (r_cnt == 8'hFF);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        mem_read     = 1'b0;
        mem_read_idx = 12'd0;
        pix_valid    = 1'b0;
        pix_data     = 1'b0;
        pix_x        = 6'd0;
        pix_y        = 5'd0;
        pix_last     = 1'b0;
        w_hs         = 1'b0;
        w_ack_ok     = 1'b0;
        w_byte_end   = 1'b0;
        w_load_shreg = 1'b0;
        w_load_byte  = mem_read_byte;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_REQ;
            end
            S_REQ: begin
                mem_read     = !mem_read_ack;
                mem_read_idx = FB_BASE + {4'd0, r_cnt};
                // r_pend rejects an ack in the same cycle the request rises
                w_ack_ok     = mem_read_ack && r_pend;
                if (w_ack_ok) begin
                    w_load_shreg = 1'b1;
                    w_next       = S_SHIFT;
                end
            end
            S_SHIFT: begin
                pix_valid  = 1'b1;
                pix_data   = r_shreg[7];
                pix_x      = {r_cnt[2:0], w_col};
                pix_y      = r_cnt[7:3];
                pix_last   = w_last_byte && (r_bit == 3'd0);
                w_hs       = pix_ready;
                w_byte_end = pix_ready && (r_bit == 3'd0);
`ifdef FB_SCANOUT_PREFETCH_EN
                if (r_pf_req) begin
                    mem_read     = !mem_read_ack;
                    mem_read_idx = FB_BASE + {4'd0, r_cnt} + 12'd1;
                    w_ack_ok     = mem_read_ack && r_pend;
                end
                if (w_byte_end) begin
                    if (w_last_byte) begin
                        w_next = S_IDLE;
                    end else if (r_pf_full) begin
                        w_load_shreg = 1'b1;
                        w_load_byte  = r_pf_buf;
                    end else if (w_ack_ok) begin
                        // prefetch lands exactly on the last bit: bypass the buffer
                        w_load_shreg = 1'b1;
                    end else begin
                        // prefetch still in flight; REQ keeps the same read open
                        w_next = S_REQ;
                    end
                end
`else
                if (w_byte_end) w_next = w_last_byte ? S_IDLE : S_REQ;
`endif
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= 8'd0;
            r_bit   <= 3'd0;
            r_shreg <= 8'd0;
            r_pend  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // a request is outstanding from the cycle after mem_read was high
            r_pend <= mem_read;
            r_done <= w_byte_end && w_last_byte;
            if (r_state == S_IDLE && start) r_cnt <= 8'd0;
            if (w_byte_end && !w_last_byte) r_cnt <= r_cnt + 8'd1;
            if (w_load_shreg) begin
                r_shreg <= w_load_byte;
                r_bit   <= 3'd7;
            end else if (w_hs) begin
                r_shreg <= {r_shreg[6:0], 1'b0};
                r_bit   <= r_bit - 3'd1;
            end
        end
    end

`ifdef FB_SCANOUT_PREFETCH_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pf_req  <= 1'b0;
            r_pf_full <= 1'b0;
            r_pf_buf  <= 8'd0;
        end else begin
            if (w_load_shreg) begin
                // byte entering SHIFT is r_cnt (from REQ) or r_cnt+1 (from
                // SHIFT); no prefetch is issued while byte 255 shifts
                r_pf_req  <= (r_state == S_SHIFT) ? (r_cnt != 8'hFE) : (r_cnt != 8'hFF);
                r_pf_full <= 1'b0;
            end else if (r_state == S_SHIFT && w_ack_ok) begin
                r_pf_req  <= 1'b0;
                r_pf_full <= 1'b1;
                r_pf_buf  <= mem_read_byte;
            end else if (r_state == S_SHIFT && w_next == S_REQ) begin
                r_pf_req  <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: two instances (FB_BASE 'h100 and 'hF80) share one
// byte-addressed memory array; each has its own ack responder with random
// latency, random pix_ready, and a pixel scoreboard fed by a frame model.
module tb_fb_scanout;

    localparam int NPIX = 2048;
`ifdef FB_SCANOUT_PREFETCH_EN
    localparam int FRAME_CYC = 2050;
`else
    localparam int FRAME_CYC = 2560;
`endif
    localparam logic [11:0] BASE0 = 12'h100;
    localparam logic [11:0] BASE1 = 12'hF80;
    localparam int PAT_SPARSE  = 0;
    localparam int PAT_LOWBYTE = 1;
    localparam int PAT_RANDOM  = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [1:0]        start = '0;
    logic [1:0]        busy, frame_done, mem_read, pix_valid, pix_data, pix_last;
    logic [1:0][11:0]  mem_read_idx;
    logic [1:0]        mem_read_ack = '0;
    logic [1:0][7:0]   mem_read_byte = '0;
    logic [1:0]        pix_ready = '0;
    logic [1:0][5:0]   pix_x;
    logic [1:0][4:0]   pix_y;
    logic [1:0][1:0]   dbg_state;

    fb_scanout #(.FB_BASE(BASE0)) dut (
        .clk(clk), .reset(reset), .start(start[0]), .busy(busy[0]),
        .frame_done(frame_done[0]), .mem_read(mem_read[0]),
        .mem_read_idx(mem_read_idx[0]), .mem_read_ack(mem_read_ack[0]),
        .mem_read_byte(mem_read_byte[0]), .pix_valid(pix_valid[0]),
        .pix_ready(pix_ready[0]), .pix_data(pix_data[0]), .pix_x(pix_x[0]),
        .pix_y(pix_y[0]), .pix_last(pix_last[0]), .o_dbg_state(dbg_state[0])
    );

    fb_scanout #(.FB_BASE(BASE1)) dut_w (
        .clk(clk), .reset(reset), .start(start[1]), .busy(busy[1]),
        .frame_done(frame_done[1]), .mem_read(mem_read[1]),
        .mem_read_idx(mem_read_idx[1]), .mem_read_ack(mem_read_ack[1]),
        .mem_read_byte(mem_read_byte[1]), .pix_valid(pix_valid[1]),
        .pix_ready(pix_ready[1]), .pix_data(pix_data[1]), .pix_x(pix_x[1]),
        .pix_y(pix_y[1]), .pix_last(pix_last[1]), .o_dbg_state(dbg_state[1])
    );

    // ---------------- bench state ----------------
    logic [7:0]  mem [4096];
    logic [12:0] exp_q[$];      // instance 0: {last, y, x, data}
    logic [12:0] exp_q_w[$];    // instance 1
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rdy_pct = 100;
    int lat_lo = 1;
    int lat_hi = 1;
    logic check_len = 1'b0;
    int exp_cycles = 0;

    logic [1:0]       pend = '0;
    logic [1:0]       ack_now = '0;
    logic [1:0]       new_req = '0;
    logic [1:0]       stall_prev = '0;
    logic [1:0]       busy_prev = '0;
    logic [1:0][12:0] prev_vec = '0;
    int cnt[2] = '{0, 0};
    logic [11:0] paddr[2] = '{12'd0, 12'd0};
    int npix[2] = '{0, 0};
    int nlit[2] = '{0, 0};
    int nframes[2] = '{0, 0};
    int busy_start[2] = '{0, 0};
    int last_hs[2] = '{0, 0};

    typedef struct {
        int inst;
        int pat;
        int rdy;
        int lo;
        int hi;
        int cyc_exp;   // 0 = frame length not checked
        int lit_exp;   // -1 = lit count not checked
    } vec_t;
    vec_t vecs[6];

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    function automatic int exp_size(input int k);
        return (k == 0) ? exp_q.size() : exp_q_w.size();
    endfunction

    function automatic logic [12:0] pop_exp(input int k);
        if (k == 0) return exp_q.pop_front();
        return exp_q_w.pop_front();
    endfunction

    function automatic logic [31:0] outs_of(input int k);
        return {3'd0, busy[k], frame_done[k], mem_read[k], mem_read_idx[k],
                pix_valid[k], pix_data[k], pix_x[k], pix_y[k], pix_last[k]};
    endfunction

    task automatic fill_mem(input int pat);
        for (int a = 0; a < 4096; a++) begin
            if (pat == PAT_LOWBYTE)     mem[a] = 8'(a);
            else if (pat == PAT_RANDOM) mem[a] = 8'($urandom);
            else                        mem[a] = 8'h00;
        end
        if (pat == PAT_SPARSE) begin
            mem[12'h100] = 8'h80;
            mem[12'h1FF] = 8'h01;
        end
    endtask

    // Reference frame: pixels in raster order, each taken from the byte at
    // base + y*8 + x/8 (mod 4096), bit 7 - x%8.
    task automatic push_frame(input int k);
        logic [11:0] base;
        logic [11:0] a;
        logic [7:0]  b;
        logic [12:0] v;
        int x;
        int y;
        base = (k == 0) ? BASE0 : BASE1;
        for (int p = 0; p < NPIX; p++) begin
            y = p / 64;
            x = p % 64;
            a = base + 12'(y * 8 + x / 8);
            b = mem[a];
            v = {(p == NPIX - 1), 5'(y), 6'(x), b[7 - x % 8]};
            if (k == 0) exp_q.push_back(v);
            else        exp_q_w.push_back(v);
        end
    endtask

    // ---------------- per-cycle responder + monitor ----------------
    task automatic sample_inst(input int k);
        logic [12:0] cur;
        logic [12:0] e;
        cur = {pix_last[k], pix_y[k], pix_x[k], pix_data[k]};
        new_req[k] = 1'b0;
        if (ack_now[k]) begin
            check("mem_read_low_on_ack", 32'(mem_read[k]), 32'd0);
        end else if (pend[k]) begin
            if (!reset)
                check("idx_stable", {19'd0, mem_read[k], mem_read_idx[k]}, {19'd0, 1'b1, paddr[k]});
        end else if (mem_read[k]) begin
            pend[k]    = 1'b1;
            cnt[k]     = $urandom_range(lat_hi, lat_lo);
            paddr[k]   = mem_read_idx[k];
            new_req[k] = 1'b1;
        end
        if (reset && pend[k]) cnt[k] = 1;   // stray ack lands right after reset

        if (stall_prev[k])
            check("stall_hold", {18'd0, pix_valid[k], cur}, {18'd0, 1'b1, prev_vec[k]});
        if (pix_valid[k] && pix_ready[k]) begin
            if (exp_size(k) == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL extra_pixel: inst %0d got pixel %0h expected none", k, cur);
            end else begin
                e = pop_exp(k);
                check("pixel", 32'(cur), 32'(e));
            end
            npix[k]++;
            nlit[k] += int'(pix_data[k]);
            last_hs[k] = cyc;
        end
        stall_prev[k] = pix_valid[k] && !pix_ready[k] && !reset;
        prev_vec[k]   = cur;
        if (busy[k] && !busy_prev[k]) busy_start[k] = cyc;
        busy_prev[k] = busy[k];
        if (frame_done[k]) begin
            check("done_one_after_last", cyc - last_hs[k], 1);
            check("busy_low_at_done", 32'(busy[k]), 32'd0);
            if (check_len) check("frame_cycles", cyc - busy_start[k], exp_cycles);
            nframes[k]++;
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            ack_now[k] = 1'b0;
            if (pend[k]) begin
                cnt[k]--;
                if (cnt[k] <= 0) begin
                    ack_now[k] = 1'b1;
                    pend[k]    = 1'b0;
                end
            end
            mem_read_ack[k]  = ack_now[k];
            mem_read_byte[k] = ack_now[k] ? mem[paddr[k]] : 8'($urandom);
            pix_ready[k]     = ($urandom_range(99, 0) < rdy_pct);
        end
        #1;
        for (int k = 0; k < 2; k++) sample_inst(k);
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start(input int k);
        @(negedge clk);
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
    endtask

    task automatic wait_frames(input int k, input int target, input int budget);
        int n;
        n = 0;
        while (nframes[k] < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        #2;
        check("frame_done_seen", 32'(nframes[k] >= target), 32'd1);
    endtask

    task automatic run_frame(input vec_t v);
        int f0;
        fill_mem(v.pat);
        rdy_pct    = v.rdy;
        lat_lo     = v.lo;
        lat_hi     = v.hi;
        check_len  = (v.cyc_exp != 0);
        exp_cycles = v.cyc_exp;
        push_frame(v.inst);
        npix[v.inst] = 0;
        nlit[v.inst] = 0;
        f0 = nframes[v.inst];
        pulse_start(v.inst);
        wait_frames(v.inst, f0 + 1, 30000);
        check("pixel_count", npix[v.inst], NPIX);
        check("queue_drained", exp_size(v.inst), 0);
        if (v.lit_exp >= 0) check("lit_count", nlit[v.inst], v.lit_exp);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int f0;
        logic fired;
        vec_t v;

        vecs[0] = '{0, PAT_SPARSE,  100, 1, 1,  FRAME_CYC, 2};
        vecs[1] = '{0, PAT_LOWBYTE, 60,  1, 1,  0,         1024};
        vecs[2] = '{0, PAT_RANDOM,  100, 1, 12, 0,         -1};
        vecs[3] = '{0, PAT_RANDOM,  50,  1, 3,  0,         -1};
        vecs[4] = '{1, PAT_LOWBYTE, 100, 1, 1,  FRAME_CYC, 1024};
        vecs[5] = '{1, PAT_RANDOM,  70,  1, 4,  0,         -1};

        repeat (3) @(negedge clk);
        #2;
        check("reset_outs_inst0", outs_of(0), 32'd0);
        check("reset_outs_inst1", outs_of(1), 32'd0);
        check("reset_state_inst0", 32'(dbg_state[0]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) run_frame(vecs[i]);

        // reset in the middle of a frame while a read is outstanding
        fill_mem(PAT_RANDOM);
        rdy_pct   = 100;
        lat_lo    = 5;
        lat_hi    = 5;
        check_len = 1'b0;
        push_frame(0);
        npix[0] = 0;
        pulse_start(0);
        n = 0;
        fired = 1'b0;
        while (!fired && n < 20000) begin
            @(negedge clk);
            #2;
            n++;
            if (npix[0] >= 700 && new_req[0]) fired = 1'b1;
        end
        check("reset_trigger_seen", 32'(fired), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #2;
        check("outs_zero_after_reset", outs_of(0), 32'd0);
        exp_q.delete();
        f0 = nframes[0];
        repeat (3) begin
            @(negedge clk);
            #2;
            check("idle_after_stray_ack", {29'd0, busy[0], mem_read[0], pix_valid[0]}, 32'd0);
        end
        check("no_done_after_reset", nframes[0], f0);
        v = '{0, PAT_LOWBYTE, 100, 1, 1, FRAME_CYC, 1024};
        run_frame(v);

        // start mid-frame is ignored; start in the frame_done cycle restarts
        fill_mem(PAT_RANDOM);
        rdy_pct    = 100;
        lat_lo     = 1;
        lat_hi     = 1;
        check_len  = 1'b1;
        exp_cycles = FRAME_CYC;
        push_frame(0);
        push_frame(0);
        npix[0] = 0;
        f0 = nframes[0];
        pulse_start(0);
        repeat (300) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        n = 0;
        fired = 1'b0;
        while (!fired && n < 5000) begin
            @(negedge clk);
            #2;
            n++;
            if (pix_valid[0] && pix_ready[0] && pix_last[0]) fired = 1'b1;
        end
        check("last_pixel_seen", 32'(fired), 32'd1);
        @(negedge clk);
        start[0] = 1'b1;
        #2;
        check("done_cycle_busy_low", {30'd0, frame_done[0], busy[0]}, 32'd2);
        @(negedge clk);
        start[0] = 1'b0;
        #2;
        check("busy_after_restart", {30'd0, frame_done[0], busy[0]}, 32'd1);
        wait_frames(0, f0 + 2, 6000);
        check("two_frame_pixels", npix[0], 2 * NPIX);
        check("two_frame_queue", exp_size(0), 0);
        repeat (50) @(negedge clk);
        #2;
        check("no_extra_frame", nframes[0], f0 + 2);
        check("idle_at_end", 32'(busy[0]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fb_scanout.md
# fb_scanout

- Reads the 256-byte CHIP-8 framebuffer (64×32 pixels, 1 bit each) out of CPU memory.
- Uses the same single-byte read request/ack protocol the CPU uses for its loads.
- Serializes the pixels onto a valid/ready pixel stream for the display driver.
- Sits on the read side of the framebuffer the CPU writes: CLS and DRW write it, this block reads it once per `start` pulse.

## Interface
Parameters:
- `FB_BASE`, default `'h100`: 12-bit address of framebuffer byte 0.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`, in, 1: clock.
  - `reset`, in, 1: synchronous reset, active-high.
- Control:
  - `start`, in, 1: begin one frame; sampled only in IDLE.
  - `busy`, out, 1: high from the cycle after `start` is accepted until the last pixel is accepted.
  - `frame_done`, out, 1: one-cycle pulse after the last pixel handshake.
- Memory read port:
  - `mem_read`, out, 1: read request.
  - `mem_read_idx`, out, 12: byte address; stable while `mem_read` is high.
  - `mem_read_ack`, in, 1: response strobe; `mem_read_byte` is valid in the same cycle.
  - `mem_read_byte`, in, 8: read data.
- Pixel stream:
  - `pix_valid`, out, 1: pixel available.
  - `pix_ready`, in, 1: sink accepts; a handshake occurs when both are high.
  - `pix_data`, out, 1: pixel value (1 = lit).
  - `pix_x`, out, 6: column 0..63.
  - `pix_y`, out, 5: row 0..31.
  - `pix_last`, out, 1: high with pixel (63,31).

## Operation
- Byte n (0..255) is read from `FB_BASE + n`.
- Byte n covers row `n[7:3]` and columns `8*n[2:0]` .. `8*n[2:0]+7`.
- Within a byte, bit 7 is the leftmost pixel: MSB first.
- States:
  - IDLE: `start` → REQ, byte counter = 0.
  - REQ: `mem_read = !mem_read_ack`, `mem_read_idx = FB_BASE + counter`. On `mem_read_ack`: latch `mem_read_byte` into the shift register, bit counter = 7 → SHIFT.
  - SHIFT: `pix_valid = 1`, `pix_data = shreg[7]`. On handshake: shift left. After bit 0 is accepted: if counter = 255 → IDLE with `frame_done`; else counter+1 → REQ.
- `pix_x = {counter[2:0], 3'd7 - bitcnt}`, `pix_y = counter[7:3]`.
- Address arithmetic is 12-bit and wraps modulo 4096; `FB_BASE` is not checked.
- While `pix_ready` is low, `pix_valid`, `pix_data`, `pix_x`, `pix_y` and `pix_last` hold.
- Only one read is outstanding at a time. An ack seen outside REQ, or outside the prefetch window (see Configuration), is ignored.
- `start` while busy is ignored. `start` in the `frame_done` cycle is accepted.
- `reset` at any time:
  - state → IDLE.
  - All outputs 0: `busy`, `frame_done`, `mem_read`, `mem_read_idx`, `pix_valid`, `pix_data`, `pix_x`, `pix_y`, `pix_last`.
  - Counters cleared; any outstanding read is abandoned.
  - A late ack after reset is ignored.

## Timing
- Memory with 1-cycle ack (CPU memory):
  - Cycle 0: REQ drives `mem_read = 1`.
  - Cycle 1: ack; byte latched.
  - Cycle 2: first `pix_valid`.
- Without prefetch:
  - 10 cycles per byte with `pix_ready` tied high.
  - Frame = 2560 cycles from `start` accept to `frame_done`, ±1 for the registered start.
- `frame_done` is asserted in the cycle after the final handshake; `busy` falls in that same cycle.
- An ack arriving in the same cycle `mem_read` is first raised is not a valid response. Acks are accepted only from the cycle after the request.
- Arbitrary ack latency is tolerated: `mem_read` stays high until the ack.

## Configuration
- `FB_SCANOUT_PREFETCH_EN` defined:
  - A second 8-bit buffer is added.
  - The fetch of byte n+1 is issued on the first SHIFT cycle of byte n, and the byte is held when acked.
  - When bit 0 is accepted, the next byte moves directly into SHIFT with no bubble.
  - Pixel stream is gapless with `pix_ready` high: frame = 2 + 256×8 = 2050 cycles.
  - No prefetch is issued for byte 255.
- Not defined: single buffer, REQ between every byte, 10 cycles/byte as above.

## Test plan
- Memory `'h100..'h1FF` = `'h00` except `'h100 = 'h80`, `'h1FF = 'h01`; `pix_ready` = 1; pulse `start`.
  - Exactly 2048 pixels.
  - (0,0) = 1, (63,31) = 1 with `pix_last`, all others 0.
  - `frame_done` 1 cycle after the last pixel; 2560 cycles (2050 with prefetch).
- `pix_ready` toggling pseudo-randomly, memory = address-low byte.
  - Every pixel matches `mem[FB_BASE + y*8 + x/8]` bit `7 - x%8`.
  - Outputs stable while stalled.
- Ack latency 1..5 random cycles.
  - `mem_read_idx` stable until the ack.
  - Never two outstanding reads; data correct.
- `reset` asserted at pixel 700 with a read outstanding, ack delivered the next cycle.
  - All outputs 0 after the reset cycle; the stray ack is ignored.
  - The next `start` produces a full, correct 2048-pixel frame.
- `start` pulsed mid-frame: ignored, one frame only.
  - `start` in the `frame_done` cycle: a second frame begins; `busy` is low for exactly that cycle.
- `FB_BASE = 'hF80`: addresses wrap from `'hFFF` to `'h000` at byte 128, and the data read follows the wrap.
